// File: rtl/riscv_dmem_resp.sv
// riscv_dmem_resp
// Byte-wide data memory responder for a simple RISC-V core. Services one
// request at a time: SB (byte store) or LBU (byte load, zero-extended).
// Loads see WAIT_CYCLES extra edges of latency; stores answer at once.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   req_valid  core presents a request
//   req_ready  block can accept a request (IDLE only)
//   req_we     1 = SB, 0 = LBU
//   req_addr   byte address (word = [BYTE_ADDR_W-1:2], lane = [1:0])
//   req_wdata  store byte
//   rsp_valid  response available (RESP only)
//   rsp_ready  core consumes the response
//   rsp_rdata  load byte zero-extended, 0 for stores
//   rsp_we     req_we of the request being answered
module riscv_dmem_resp #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_W      = 10,
  parameter int BYTE_ADDR_W = ADDR_W + 2,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [BYTE_ADDR_W-1:0] req_addr,
  input  logic [7:0]             req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_WIDTH-1:0]  rsp_rdata,
  output logic                   rsp_we
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t                  state_q, state_d;
  logic [2:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    we_q, we_d;
  // Held low in reset and raised on the first edge after release, so
  // req_ready stays low while rst_n is asserted without rst_n feeding logic.
  logic                    live_q;

  logic [DATA_WIDTH-1:0]   mem_q [0:2**ADDR_W-1];

  logic [ADDR_W-1:0]       word;
  logic [1:0]              lane;
  logic [7:0]              rd_byte;
  logic                    accept;

  assign word    = req_addr[BYTE_ADDR_W-1:2];
  assign lane    = req_addr[1:0];
  assign rd_byte = mem_q[word][{lane, 3'b000} +: 8];

  assign req_ready = live_q && (state_q == IDLE);
  assign accept    = req_valid && req_ready;

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_we    = we_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d    = req_we;
          rdata_d = req_we ? '0 : {{(DATA_WIDTH-8){1'b0}}, rd_byte};
          if (req_we || (WAIT_CYCLES == 0)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(WAIT_CYCLES - 1);
          end
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      live_q  <= 1'b1;
    end
  end

  // Storage is deliberately not reset; only the addressed lane is written.
  always_ff @(posedge clk) begin
    if (accept && req_we) begin
      mem_q[word][{lane, 3'b000} +: 8] <= req_wdata;
    end
  end

endmodule
